// File: rtl/instr_fetch_buffer_if.sv
// PC-side and instruction-memory-side signals of the fetch buffer.
// The buffer takes the slave view; the PC/memory environment takes the master view.
interface instr_fetch_buffer_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic [ADDR_W-1:0] pc_addr;
  logic              invalidate;
  logic [15:0]       instr;
  logic              instr_valid;
  logic              stall;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              mem_data_valid;

  modport master (
    output pc_addr,
    output invalidate,
    output mem_data,
    output mem_data_valid,
    input  instr,
    input  instr_valid,
    input  stall,
    input  mem_rd_en,
    input  mem_addr
  );

  modport slave (
    input  pc_addr,
    input  invalidate,
    input  mem_data,
    input  mem_data_valid,
    output instr,
    output instr_valid,
    output stall,
    output mem_rd_en,
    output mem_addr
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Single-line instruction fetch buffer: combinational hits, whole-line refill on a miss.
// stall holds the PC while the line is being fetched from multi-cycle memory.
module instr_fetch_buffer #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 16
) (
  input logic                  clk,
  input logic                  rst,
  instr_fetch_buffer_if.slave  bus
);

  localparam int unsigned OffW = $clog2(LINE_WORDS);
  localparam int unsigned CntW = OffW + 1;
  localparam int unsigned TagW = ADDR_W - OffW - 1;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e            state_q, state_d;
  logic [15:0]       line_q [LINE_WORDS];
  logic [TagW-1:0]   line_tag_q;
  logic              line_valid_q;
  logic [CntW-1:0]   req_cnt_q;
  logic [CntW-1:0]   rsp_cnt_q;
  logic              inval_pending_q;

  logic [OffW-1:0]   offset;
  logic [TagW-1:0]   tag;
  logic              hit;
  logic              req_fire;
  logic              rsp_wr;
  logic              fill_done;
  logic              unused_pc_bit0;

  assign offset         = bus.pc_addr[OffW:1];
  assign tag            = bus.pc_addr[ADDR_W-1:OffW+1];
  assign unused_pc_bit0 = bus.pc_addr[0];

  assign hit       = line_valid_q && (tag == line_tag_q) && (state_q == StIdle);
  assign req_fire  = (state_q == StFill) && (req_cnt_q < CntW'(LINE_WORDS));
  // Responses beyond the line length cannot legally occur; the guard keeps them harmless.
  assign rsp_wr    = (state_q == StFill) && bus.mem_data_valid && (rsp_cnt_q < CntW'(LINE_WORDS));
  assign fill_done = rsp_wr && (rsp_cnt_q == CntW'(LINE_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!hit) state_d = StFill;
      StFill:  if (fill_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.instr       = 16'h0000;
    bus.instr_valid = 1'b0;
    bus.stall       = 1'b1;
    bus.mem_rd_en   = 1'b0;
    bus.mem_addr    = '0;
    if (hit) begin
      bus.instr       = line_q[offset];
      bus.instr_valid = 1'b1;
      bus.stall       = 1'b0;
    end
    if (state_q == StFill) begin
      bus.mem_rd_en = req_fire;
      bus.mem_addr  = {line_tag_q, req_cnt_q[OffW-1:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid_q    <= 1'b0;
      line_tag_q      <= '0;
      req_cnt_q       <= '0;
      rsp_cnt_q       <= '0;
      inval_pending_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.invalidate) line_valid_q <= 1'b0;
          if (!hit) begin
            line_tag_q   <= tag;
            line_valid_q <= 1'b0;
            req_cnt_q    <= '0;
            rsp_cnt_q    <= '0;
          end
        end
        StFill: begin
          if (req_fire) req_cnt_q <= req_cnt_q + CntW'(1);
          if (rsp_wr) rsp_cnt_q <= rsp_cnt_q + CntW'(1);
          if (bus.invalidate) inval_pending_q <= 1'b1;
          // An invalidate seen at any point of the fill, including its last cycle, leaves the line dead.
          if (fill_done) begin
            line_valid_q    <= !(inval_pending_q || bus.invalidate);
            inval_pending_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rsp_wr) begin
      line_q[rsp_cnt_q[OffW-1:0]] <= bus.mem_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed and randomized checks of instr_fetch_buffer against a queue-based line/memory model.
module tb_instr_fetch_buffer;

  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_buffer_if #(.ADDR_W(16)) bus ();

  instr_fetch_buffer #(
    .LINE_WORDS (LW),
    .ADDR_W     (16)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the buffered line and the outstanding fill as plain arrays/queues.
  bit          m_known = 1'b0;
  bit          m_busy;
  bit          m_valid;
  bit          m_pend;
  int          m_tag;
  int          m_rsp_idx;
  logic [15:0] m_line [LW];
  int          m_req_q [$];

  // Memory model: in-order responses, each at least one cycle after its request.
  typedef struct {
    int addr;
    int due;
  } rsp_t;
  rsp_t mq [$];
  int   last_due = 0;
  int   cyc      = 0;
  int   lat_lo   = 4;
  int   lat_hi   = 4;
  int   epoch    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] golden(input int word, input int ep);
    if (ep == 0) return 16'(32'hA000 + word);
    return 16'(word * 40503 + ep * 977 + 17);
  endfunction

  function automatic bit model_hit();
    return m_valid && !m_busy && (int'(bus.pc_addr[15:4]) == m_tag);
  endfunction

  task automatic tick();
    bit          ph;
    bit          er;
    logic [15:0] ei;
    int          d;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = golden(mq[0].addr >> 1, epoch);
      void'(mq.pop_front());
    end else begin
      bus.mem_data_valid = 1'b0;
      bus.mem_data       = 16'($urandom);
    end
    #1;
    ph = model_hit();
    ei = ph ? m_line[int'(bus.pc_addr[3:1])] : 16'h0000;
    er = m_busy && (m_req_q.size() > 0);
    if (m_known) begin
      check_eq("instr", bus.instr, ei);
      check_eq("instr_valid", bus.instr_valid, ph);
      check_eq("stall", bus.stall, !ph);
      check_eq("mem_rd_en", bus.mem_rd_en, er);
      if (er) check_eq("mem_addr", bus.mem_addr, m_req_q[0]);
      else if (!m_busy) check_eq("mem_addr_idle", bus.mem_addr, 0);
    end
    if (bus.mem_rd_en === 1'b1) begin
      d = cyc + int'($urandom_range(lat_lo, lat_hi));
      if (d <= last_due) d = last_due + 1;
      mq.push_back('{addr: int'(bus.mem_addr), due: d});
      last_due = d;
    end
    @(posedge clk);
    if (rst) begin
      m_known   = 1'b1;
      m_busy    = 1'b0;
      m_valid   = 1'b0;
      m_pend    = 1'b0;
      m_tag     = 0;
      m_rsp_idx = 0;
      m_req_q.delete();
    end else if (m_known) begin
      if (bus.invalidate) epoch++;
      if (!m_busy) begin
        if (bus.invalidate) m_valid = 1'b0;
        if (!ph) begin
          m_busy    = 1'b1;
          m_valid   = 1'b0;
          m_pend    = 1'b0;
          m_tag     = int'(bus.pc_addr[15:4]);
          m_rsp_idx = 0;
          for (int i = 0; i < LW; i++) m_req_q.push_back((m_tag << 4) | (i << 1));
        end
      end else begin
        if (m_req_q.size() > 0) void'(m_req_q.pop_front());
        if (bus.invalidate) m_pend = 1'b1;
        if (bus.mem_data_valid) begin
          m_line[m_rsp_idx] = bus.mem_data;
          m_rsp_idx++;
          if (m_rsp_idx == LW) begin
            m_busy  = 1'b0;
            m_valid = !m_pend;
            m_pend  = 1'b0;
          end
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_hit(input string tag, input int budget);
    for (int k = 0; k < budget && !model_hit(); k++) tick();
    #1;
    check_eq(tag, bus.instr_valid, 1);
  endtask

  initial begin
    rst                = 1'b1;
    bus.pc_addr        = 16'h0000;
    bus.invalidate     = 1'b0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data       = 16'h0000;

    // Reset held two cycles at pc 0.
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("t1_valid", bus.instr_valid, 0);
    check_eq("t1_stall", bus.stall, 1);
    check_eq("t1_rd_en", bus.mem_rd_en, 0);

    // Cold miss at 0, latency 4: requests in cycles 1..8, first hit in cycle 13.
    for (int c = 0; c < 13; c++) begin
      #1;
      check_eq("t2_stall", bus.stall, 1);
      check_eq("t2_rd_en", bus.mem_rd_en, (c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) check_eq("t2_addr", bus.mem_addr, (c - 1) * 2);
      tick();
    end
    #1;
    check_eq("t2_c13_valid", bus.instr_valid, 1);
    check_eq("t2_c13_instr", bus.instr, 16'hA000);

    // Sequential hits across the line.
    for (int k = 1; k < LW; k++) begin
      bus.pc_addr = 16'(2 * k);
      #1;
      check_eq("t3_instr", bus.instr, 32'hA000 + k);
      check_eq("t3_stall", bus.stall, 0);
      check_eq("t3_rd_en", bus.mem_rd_en, 0);
      tick();
    end

    // Next line, then back to the first: single line, so both miss.
    bus.pc_addr = 16'h0010;
    wait_hit("t4_hit_0010", 60);
    check_eq("t4_instr_0010", bus.instr, 16'hA008);
    bus.pc_addr = 16'h0004;
    #1;
    check_eq("t4_miss_0004", bus.stall, 1);
    wait_hit("t4_hit_0004", 60);
    check_eq("t4_instr_0004", bus.instr, 16'hA002);

    // Reset in cycle 3 of a fill, held until the stale responses have drained.
    bus.pc_addr = 16'h0020;
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    rst = 1'b0;
    #1;
    check_eq("t5_valid_after_rst", bus.instr_valid, 0);
    wait_hit("t5_hit", 60);
    check_eq("t5_instr", bus.instr, 16'hA010);

    // Invalidate in cycle 5 of a fill: the fill completes, then the line is refetched.
    bus.pc_addr = 16'h0030;
    for (int c = 0; c < 5; c++) tick();
    bus.invalidate = 1'b1;
    tick();
    bus.invalidate = 1'b0;
    for (int k = 0; k < 40 && m_busy; k++) tick();
    #1;
    check_eq("t6_dead_line", bus.instr_valid, 0);
    tick();
    #1;
    check_eq("t6_refill_rd_en", bus.mem_rd_en, 1);
    check_eq("t6_refill_addr", bus.mem_addr, 16'h0030);
    wait_hit("t6_refill_hit", 60);
    check_eq("t6_refill_data", bus.instr, golden(24, 1));

    // Invalidate in IDLE: same-cycle hit keeps old data, next cycle misses.
    bus.invalidate = 1'b1;
    #1;
    check_eq("t6_idle_inval_hit", bus.instr_valid, 1);
    tick();
    bus.invalidate = 1'b0;
    #1;
    check_eq("t6_idle_inval_miss", bus.instr_valid, 0);
    wait_hit("t6_idle_refill_hit", 60);
    check_eq("t6_idle_refill_data", bus.instr, golden(24, 2));

    // Randomized traffic with variable memory latency.
    lat_lo = 1;
    lat_hi = 5;
    for (int n = 0; n < 3000; n++) begin
      int sel;
      if ($urandom_range(0, 9) < 3) begin
        sel = int'($urandom_range(0, 3));
        bus.pc_addr = 16'(((sel == 3 ? 12'hFFF : sel) << 4) | $urandom_range(0, 15));
      end
      bus.invalidate = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        rst = 1'b0;
      end
      tick();
    end
    bus.invalidate = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
